// File: rtl/tcdm_fill_check_master.sv
// TCDM bus initiator: fills a word range with a programmable pattern or reads it back and
// counts mismatches, keeping up to MAX_OUTST requests in flight.
module tcdm_fill_check_master #(
    parameter int unsigned MAX_OUTST = 2,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned ERRCNT_W  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                mode_i,
    input  logic                incr_i,
    input  logic [31:0]         base_i,
    input  logic [CNT_W-1:0]    nwords_i,
    input  logic [31:0]         pattern_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [ERRCNT_W-1:0] err_cnt_o,
    output logic [31:0]         first_err_addr_o,
    output logic                opc_err_o,
    output logic                tcdm_req_o,
    output logic [31:0]         tcdm_add_o,
    output logic                tcdm_wen_o,
    output logic [31:0]         tcdm_wdata_o,
    output logic [3:0]          tcdm_be_o,
    input  logic                tcdm_gnt_i,
    input  logic                tcdm_r_valid_i,
    input  logic [31:0]         tcdm_r_rdata_i,
    input  logic                tcdm_r_opc_i
);

    localparam int unsigned      OUT_W   = $clog2(MAX_OUTST + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e             state;
    logic               mode_q;
    logic               incr_q;
    logic [CNT_W-1:0]   rem_q;      // words still to be issued
    logic [31:0]        rsp_add_q;  // address of the word the next response belongs to
    logic [31:0]        rsp_pat_q;  // expected data of the next response
    logic [OUT_W-1:0]   outst_q;
    logic [OUT_W-1:0]   outst_d;
    logic               fire;
    logic               rsp_ok;
    logic               last_fire;
    logic               mismatch;

    assign tcdm_be_o = 4'hF;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no latch can be inferred.
        fire      = tcdm_req_o & tcdm_gnt_i;
        rsp_ok    = tcdm_r_valid_i & ((outst_q != '0) | fire);
        last_fire = fire & (rem_q == CNT_W'(1));
        mismatch  = rsp_ok & mode_q & (tcdm_r_rdata_i != rsp_pat_q);
        outst_d   = outst_q;
        if (fire && !rsp_ok) begin
            outst_d = outst_q + OUT_W'(1);
        end else if (!fire && rsp_ok) begin
            outst_d = outst_q - OUT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= S_IDLE;
            tcdm_req_o       <= 1'b0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            opc_err_o        <= 1'b0;
            tcdm_add_o       <= '0;
            tcdm_wdata_o     <= '0;
            tcdm_wen_o       <= 1'b1;
            first_err_addr_o <= '0;
            err_cnt_o        <= '0;
            mode_q           <= 1'b0;
            incr_q           <= 1'b0;
            rem_q            <= '0;
            rsp_add_q        <= '0;
            rsp_pat_q        <= '0;
            outst_q          <= '0;
        end else begin
            done_o  <= 1'b0;
            outst_q <= outst_d;

            if (fire) begin
                tcdm_add_o   <= tcdm_add_o + 32'd4;
                tcdm_wdata_o <= tcdm_wdata_o + {31'b0, incr_q};
                rem_q        <= rem_q - CNT_W'(1);
            end

            if (rsp_ok) begin
                rsp_add_q <= rsp_add_q + 32'd4;
                rsp_pat_q <= rsp_pat_q + {31'b0, incr_q};
                if (tcdm_r_opc_i) begin
                    opc_err_o <= 1'b1;
                end
                if (mismatch) begin
                    if (err_cnt_o == '0) begin
                        first_err_addr_o <= rsp_add_q;
                    end
                    if (err_cnt_o != '1) begin
                        err_cnt_o <= err_cnt_o + 1'b1;
                    end
                end
            end

            // NOTE: non-blocking assignments later in this block override the shared updates above.
            case (state)
                S_IDLE: begin
                    busy_o <= 1'b0;
                    if (start_i && !busy_o) begin
                        busy_o           <= 1'b1;
                        mode_q           <= mode_i;
                        incr_q           <= incr_i;
                        rem_q            <= nwords_i;
                        tcdm_add_o       <= {base_i[31:2], 2'b00};
                        rsp_add_q        <= {base_i[31:2], 2'b00};
                        tcdm_wdata_o     <= pattern_i;
                        rsp_pat_q        <= pattern_i;
                        tcdm_wen_o       <= mode_i;
                        err_cnt_o        <= '0;
                        first_err_addr_o <= '0;
                        opc_err_o        <= 1'b0;
                        outst_q          <= '0;
                        if (nwords_i == '0) begin
                            state <= S_DONE;
                        end else begin
                            state      <= S_ISSUE;
                            tcdm_req_o <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (last_fire) begin
                        state      <= S_DRAIN;
                        tcdm_req_o <= 1'b0;
                    end else begin
                        tcdm_req_o <= (outst_d < OUT_MAX);
                    end
                end
                S_DRAIN: begin
                    if (outst_d == '0) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_o <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tcdm_fill_check_master.sv
// Self-checking bench: randomized TCDM responder with a memory model, and a reference model
// of the fill/check command computed directly from addresses and patterns.
module tb_tcdm_fill_check_master;

    localparam int MAX_OUTST = 2;
    localparam int CNT_W     = 16;
    localparam int ERRCNT_W  = 16;

    logic                clk = 1'b0;
    logic                rst_i = 1'b1;
    logic                start_i = 1'b0;
    logic                mode_i = 1'b0;
    logic                incr_i = 1'b0;
    logic [31:0]         base_i = '0;
    logic [CNT_W-1:0]    nwords_i = '0;
    logic [31:0]         pattern_i = '0;
    logic                busy_o;
    logic                done_o;
    logic [ERRCNT_W-1:0] err_cnt_o;
    logic [31:0]         first_err_addr_o;
    logic                opc_err_o;
    logic                tcdm_req_o;
    logic [31:0]         tcdm_add_o;
    logic                tcdm_wen_o;
    logic [31:0]         tcdm_wdata_o;
    logic [3:0]          tcdm_be_o;
    logic                tcdm_gnt_i = 1'b0;
    logic                tcdm_r_valid_i = 1'b0;
    logic [31:0]         tcdm_r_rdata_i = '0;
    logic                tcdm_r_opc_i = 1'b0;

    always #5 clk = ~clk;

    tcdm_fill_check_master #(
        .MAX_OUTST(MAX_OUTST),
        .CNT_W    (CNT_W),
        .ERRCNT_W (ERRCNT_W)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .mode_i          (mode_i),
        .incr_i          (incr_i),
        .base_i          (base_i),
        .nwords_i        (nwords_i),
        .pattern_i       (pattern_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_cnt_o       (err_cnt_o),
        .first_err_addr_o(first_err_addr_o),
        .opc_err_o       (opc_err_o),
        .tcdm_req_o      (tcdm_req_o),
        .tcdm_add_o      (tcdm_add_o),
        .tcdm_wen_o      (tcdm_wen_o),
        .tcdm_wdata_o    (tcdm_wdata_o),
        .tcdm_be_o       (tcdm_be_o),
        .tcdm_gnt_i      (tcdm_gnt_i),
        .tcdm_r_valid_i  (tcdm_r_valid_i),
        .tcdm_r_rdata_i  (tcdm_r_rdata_i),
        .tcdm_r_opc_i    (tcdm_r_opc_i)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model of the command's word sequence.
    function automatic logic [31:0] addr_k(input logic [31:0] base, input int k);
        return {base[31:2], 2'b00} + 32'(4 * k);
    endfunction

    function automatic logic [31:0] pat_k(input logic [31:0] p, input bit incr, input int k);
        return incr ? p + 32'(k) : p;
    endfunction

    // Responder: memory, in-order responses with random latency, optional random grant stalls.
    typedef struct {
        logic [31:0] rdata;
        logic        opc;
        int          ready;
        int          epoch;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
    } gnt_t;

    logic [31:0] mem [logic [31:0]];
    rsp_t        rq[$];
    gnt_t        gseq[$];
    rsp_t        head;
    bit          stall_en = 1'b0;
    int          min_lat = 1;
    int          max_lat = 1;
    int          opc_at = -1;
    int          resp_idx = 0;
    int          tcyc = 0;
    int          epoch = 0;
    int          tb_outst = 0;
    int          peak = 0;
    int          done_cnt = 0;
    int          req_cnt = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_add;
    logic [31:0] prev_wdata;
    logic        prev_wen;
    logic [31:0] rd;

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
    endfunction

    always @(negedge clk) begin
        tcyc++;
        if (done_o) done_cnt++;
        if (tcdm_req_o) req_cnt++;
        if (tb_outst > peak) peak = tb_outst;
        if (prev_stall) begin
            check("stall_req", 32'(tcdm_req_o), 32'd1);
            check("stall_add", tcdm_add_o, prev_add);
            check("stall_wdata", tcdm_wdata_o, prev_wdata);
            check("stall_wen", 32'(tcdm_wen_o), 32'(prev_wen));
        end

        tcdm_r_valid_i = 1'b0;
        tcdm_r_opc_i   = 1'b0;
        tcdm_r_rdata_i = $urandom;
        if (rq.size() > 0 && rq[0].ready <= tcyc) begin
            head = rq.pop_front();
            tcdm_r_valid_i = 1'b1;
            tcdm_r_rdata_i = head.rdata;
            tcdm_r_opc_i   = head.opc;
            if (head.epoch == epoch) tb_outst--;
        end

        if (rst_i) begin
            tcdm_gnt_i = 1'b0;
            epoch++;
            tb_outst = 0;
        end else begin
            tcdm_gnt_i = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
        end

        prev_stall = tcdm_req_o && !tcdm_gnt_i && !rst_i;
        prev_add   = tcdm_add_o;
        prev_wdata = tcdm_wdata_o;
        prev_wen   = tcdm_wen_o;

        if (tcdm_req_o && tcdm_gnt_i) begin
            gseq.push_back('{tcdm_add_o, tcdm_wen_o, tcdm_wdata_o});
            if (!tcdm_wen_o) begin
                mem[tcdm_add_o] = tcdm_wdata_o;
                rd = 32'h0;
            end else begin
                rd = rd_mem(tcdm_add_o);
            end
            rq.push_back('{rd, (resp_idx == opc_at), tcyc + $urandom_range(max_lat, min_lat), epoch});
            resp_idx++;
            tb_outst++;
        end
    end

    // Issue one command and return the start_i -> done_o distance in cycles (-1 if none).
    task automatic run_cmd(input bit mode, input bit incr, input logic [31:0] base, input int n,
                           input logic [31:0] pat, input bit hold_start, output int lat);
        int cyc;
        @(negedge clk);
        start_i   = 1'b1;
        mode_i    = mode;
        incr_i    = incr;
        base_i    = base;
        nwords_i  = CNT_W'(n);
        pattern_i = pat;
        cyc = 0;
        lat = -1;
        do begin
            @(negedge clk);
            cyc++;
            if (hold_start && cyc <= 2) begin
                start_i  = 1'b1;
                nwords_i = CNT_W'(5);
                mode_i   = 1'b0;
                base_i   = 32'h0000_0100;
            end else begin
                start_i = 1'b0;
            end
            if (cyc == 1) check("busy_after_start", 32'(busy_o), 32'd1);
            if (done_o) lat = cyc;
        end while (lat < 0 && cyc < 2000);
        @(negedge clk);
        start_i = 1'b0;
        check("busy_after_done", 32'(busy_o), 32'd0);
        check("done_one_cycle", 32'(done_o), 32'd0);
    endtask

    task automatic do_cmd(input bit mode, input bit incr, input logic [31:0] base, input int n,
                          input logic [31:0] pat, input bit hold_start, input int exp_lat,
                          input int opc_idx);
        int          lat;
        int          exp_err;
        logic [31:0] exp_first;
        logic [31:0] a;
        int          d0;
        int          r0;
        exp_err   = 0;
        exp_first = '0;
        if (mode) begin
            for (int k = 0; k < n; k++) begin
                a = addr_k(base, k);
                if (rd_mem(a) != pat_k(pat, incr, k)) begin
                    if (exp_err == 0) exp_first = a;
                    exp_err++;
                end
            end
        end
        opc_at   = opc_idx;
        resp_idx = 0;
        gseq.delete();
        peak = 0;
        d0   = done_cnt;
        r0   = req_cnt;
        run_cmd(mode, incr, base, n, pat, hold_start, lat);
        check("done_seen", 32'(lat >= 0), 32'd1);
        if (exp_lat >= 0) check("latency", 32'(lat), 32'(exp_lat));
        check("n_grants", 32'(gseq.size()), 32'(n));
        for (int k = 0; k < gseq.size() && k < n; k++) begin
            check("req_addr", gseq[k].addr, addr_k(base, k));
            check("req_wen", 32'(gseq[k].wen), 32'(mode));
            check("req_wdata", gseq[k].wdata, pat_k(pat, incr, k));
        end
        if (!mode) begin
            for (int k = 0; k < n; k++) check("mem_word", rd_mem(addr_k(base, k)), pat_k(pat, incr, k));
        end
        check("err_cnt", 32'(err_cnt_o), 32'(exp_err));
        check("first_err_addr", first_err_addr_o, exp_first);
        check("opc_err", 32'(opc_err_o), 32'(opc_idx >= 0 && opc_idx < n));
        check("outst_le_max", 32'(peak <= MAX_OUTST), 32'd1);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        if (n == 0) check("n0_req_cycles", 32'(req_cnt - r0), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ref_words [16];
        logic [31:0] b;
        logic [31:0] p;
        bit          inc;
        bit          reached;
        int          n;
        int          d0;

        repeat (3) @(posedge clk);
        #2;
        check("rst_req", 32'(tcdm_req_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_opc", 32'(opc_err_o), 32'd0);
        check("rst_add", tcdm_add_o, 32'd0);
        check("rst_wdata", tcdm_wdata_o, 32'd0);
        check("rst_first", first_err_addr_o, 32'd0);
        check("rst_err", 32'(err_cnt_o), 32'd0);
        check("rst_wen", 32'(tcdm_wen_o), 32'd1);
        check("rst_be", 32'(tcdm_be_o), 32'hF);
        rst_i = 1'b0;
        repeat (2) @(negedge clk);

        // Directed fill / check / corrupted check.
        do_cmd(1'b0, 1'b1, 32'h1C01_0000, 4, 32'hA5A5_0000, 1'b0, 7, -1);
        do_cmd(1'b1, 1'b1, 32'h1C01_0000, 4, 32'hA5A5_0000, 1'b0, 7, -1);
        mem[32'h1C01_0008] = 32'h1234_5678;
        do_cmd(1'b1, 1'b1, 32'h1C01_0000, 4, 32'hA5A5_0000, 1'b0, 7, -1);
        check("corrupt_first", first_err_addr_o, 32'h1C01_0008);

        // Stalled fill must leave the same memory as an unstalled one.
        b = 32'h1C02_0000;
        p = $urandom;
        do_cmd(1'b0, 1'b1, b, 16, p, 1'b0, 19, -1);
        for (int k = 0; k < 16; k++) begin
            ref_words[k] = rd_mem(addr_k(b, k));
            mem[addr_k(b, k)] = 32'h0;
        end
        stall_en = 1'b1;
        do_cmd(1'b0, 1'b1, b, 16, p, 1'b0, -1, -1);
        stall_en = 1'b0;
        for (int k = 0; k < 16; k++) check("stall_mem", rd_mem(addr_k(b, k)), ref_words[k]);

        // Longer latency: the pipeline must fill up to exactly MAX_OUTST.
        min_lat = 3;
        max_lat = 3;
        do_cmd(1'b0, 1'b0, 32'h1C03_0000, 8, 32'hCAFE_0001, 1'b0, -1, -1);
        check("outst_peak", 32'(peak), 32'(MAX_OUTST));
        min_lat = 1;
        max_lat = 1;

        // Zero words, with start_i held high while busy.
        do_cmd(1'b0, 1'b1, 32'h1C04_0000, 0, 32'h1, 1'b1, 2, -1);

        // Response error on word 2 of 5, sticky until the next start.
        do_cmd(1'b0, 1'b1, 32'h1C05_0000, 5, 32'h0BAD_F00D, 1'b0, 8, -1);
        do_cmd(1'b1, 1'b1, 32'h1C05_0000, 5, 32'h0BAD_F00D, 1'b0, 8, 2);
        repeat (4) @(negedge clk);
        check("opc_sticky", 32'(opc_err_o), 32'd1);
        do_cmd(1'b0, 1'b1, 32'hFFFF_FFFB, 4, 32'h7777_0000, 1'b0, 7, -1);
        check("wrap_word2", rd_mem(32'h0000_0000), 32'h7777_0002);

        // Reset with two requests in flight.
        min_lat = 3;
        max_lat = 3;
        gseq.delete();
        d0 = done_cnt;
        @(negedge clk);
        start_i   = 1'b1;
        mode_i    = 1'b0;
        incr_i    = 1'b1;
        base_i    = 32'h1C06_0000;
        nwords_i  = CNT_W'(8);
        pattern_i = 32'h5555_0000;
        @(negedge clk);
        start_i = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            @(negedge clk);
            if (tb_outst == 2) reached = 1'b1;
        end
        check("rst_outst_reached", 32'(reached), 32'd1);
        @(posedge clk);
        #2 rst_i = 1'b1;
        @(posedge clk);
        #2;
        check("midrst_req", 32'(tcdm_req_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        check("midrst_idle_req", 32'(tcdm_req_o), 32'd0);
        check("midrst_err", 32'(err_cnt_o), 32'd0);
        min_lat = 1;
        max_lat = 1;
        do_cmd(1'b0, 1'b1, 32'h1C07_0000, 6, 32'h9999_0000, 1'b0, 9, -1);

        // Randomized fill, corrupt, check.
        for (int it = 0; it < 8; it++) begin
            n        = $urandom_range(12, 1);
            b        = 32'h2000_0000 + ($urandom & 32'h000F_FFFF);
            p        = $urandom;
            inc      = ($urandom_range(0, 1) == 1);
            stall_en = ($urandom_range(0, 1) == 1);
            max_lat  = $urandom_range(3, 1);
            do_cmd(1'b0, inc, b, n, p, 1'b0, (!stall_en && max_lat == 1) ? n + 3 : -1, -1);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(3, 0) == 0) mem[addr_k(b, k)] = rd_mem(addr_k(b, k)) ^ ($urandom | 32'h1);
            end
            do_cmd(1'b1, inc, b, n, p, 1'b0, (!stall_en && max_lat == 1) ? n + 3 : -1,
                   int'($urandom_range(n + 2, 0)));
        end
        stall_en = 1'b0;
        max_lat  = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
